// File: rtl/life_engine.sv
// life_engine: cellular-automaton core. Holds a WIDTH x HEIGHT grid and
// advances it one generation per step request, one row per clock into a
// shadow buffer, then commits the whole buffer in a single cycle.
module life_engine #(
  parameter int          WIDTH        = 8,
  parameter int          HEIGHT       = 8,
  parameter bit          WRAP         = 1'b1,
  parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0]  SURVIVE_MASK = 9'b000001100
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  load_en,
  input  logic [WIDTH*HEIGHT-1:0]               load_data,
  input  logic                                  step,
  output logic                                  busy,
  output logic                                  done,
  output logic [WIDTH*HEIGHT-1:0]               grid_out,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]     population,
  output logic [15:0]                           gen_count,
  output logic                                  stable
);

  localparam int CELLS = WIDTH * HEIGHT;
  localparam int PW    = $clog2(CELLS + 1);
  localparam int IW    = $clog2(CELLS);
  localparam int RW    = $clog2(HEIGHT);

  // state   | meaning
  // IDLE    | waiting for load_en or step
  // COMPUTE | one row of the next generation written per cycle
  // COMMIT  | next buffer copied into the grid, status updated
  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    row_q;
  logic [CELLS-1:0] grid_q;
  logic [CELLS-1:0] next_q;
  logic [WIDTH-1:0] row_bits;
  logic [PW-1:0]    pop_q;
  logic [15:0]      gen_q;
  logic             stable_q;
  logic             done_q;
  logic             last_row;

  // Cell lookup; out-of-range coordinates either wrap or read as dead.
  function automatic logic cell_at(input logic [CELLS-1:0] g, input int x, input int y);
    int  xi;
    int  yi;
    logic v;
    xi = x;
    yi = y;
    v  = 1'b0;
    if (WRAP) begin
      xi = (x + WIDTH) % WIDTH;
      yi = (y + HEIGHT) % HEIGHT;
      v  = g[IW'(yi * WIDTH + xi)];
    end else if (x >= 0 && x < WIDTH && y >= 0 && y < HEIGHT) begin
      v = g[IW'(y * WIDTH + x)];
    end
    return v;
  endfunction

  // Next-generation value of every cell in row y.
  function automatic logic [WIDTH-1:0] next_row(input logic [CELLS-1:0] g, input int y);
    logic [WIDTH-1:0] r;
    logic [3:0]       n;
    r = '0;
    for (int x = 0; x < WIDTH; x++) begin
      n = '0;
      for (int dy = -1; dy <= 1; dy++) begin
        for (int dx = -1; dx <= 1; dx++) begin
          if (dx != 0 || dy != 0) begin
            n = n + {3'b000, cell_at(g, x + dx, y + dy)};
          end
        end
      end
      r[x] = cell_at(g, x, y) ? SURVIVE_MASK[n] : BIRTH_MASK[n];
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] popcount(input logic [CELLS-1:0] v);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < CELLS; i++) begin
      p = p + PW'(v[i]);
    end
    return p;
  endfunction

  assign last_row = (row_q == RW'(HEIGHT - 1));

  // Row currently being evaluated, always from the committed grid.
  always_comb begin
    row_bits = next_row(grid_q, int'(row_q));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and busy; a load in IDLE suppresses a simultaneous step.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!load_en && step) state_d = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_row) state_d = COMMIT;
      end
      COMMIT: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grid, next buffer, row counter and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q    <= '0;
      grid_q   <= '0;
      next_q   <= '0;
      pop_q    <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == COMMIT);
      case (state_q)
        IDLE: begin
          if (load_en) begin
            grid_q   <= load_data;
            gen_q    <= '0;
            stable_q <= 1'b0;
            pop_q    <= popcount(load_data);
          end else if (step) begin
            row_q <= '0;
          end
        end
        COMPUTE: begin
          for (int x = 0; x < WIDTH; x++) begin
            next_q[IW'(int'(row_q) * WIDTH + x)] <= row_bits[x];
          end
          row_q <= last_row ? '0 : row_q + 1'b1;
        end
        COMMIT: begin
          grid_q   <= next_q;
          gen_q    <= gen_q + 16'd1;
          pop_q    <= popcount(next_q);
          stable_q <= (next_q == grid_q);
        end
        default: ;
      endcase
    end
  end

  assign done       = done_q;
  assign grid_out   = grid_q;
  assign population = pop_q;
  assign gen_count  = gen_q;
  assign stable     = stable_q;

endmodule

// File: doc/life_engine.md
# life_engine

Parametrised Conway-style cellular-automaton core that holds a WIDTH x HEIGHT cell grid and advances it one generation per `step` request. Boundary mode and birth/survive rules are configurable. It computes one row per clock, so a generation costs HEIGHT+1 cycles. It replaces the fixed-size grid logic under `top`, feeds the LED display driver through `grid_out`, and adds population and stability status.

## Interface
- WIDTH, 8: columns, 3..32.
- HEIGHT, 8: rows, 3..32.
- WRAP, 1: 1 = toroidal edges, 0 = cells outside the grid are dead.
- BIRTH_MASK, 9'b000001000: bit n set means a dead cell with n live neighbours is born.
- SURVIVE_MASK, 9'b000001100: bit n set means a live cell with n live neighbours survives.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high.
- load_en  input  1  load `load_data` into the grid; acted on only in IDLE.
- load_data  input  WIDTH*HEIGHT  cell (x,y) is bit y*WIDTH+x; 1 means alive.
- step  input  1  request one generation; acted on only in IDLE.
- busy  output  1  high while in COMPUTE or COMMIT.
- done  output  1  one-cycle pulse when a generation is committed.
- grid_out  output  WIDTH*HEIGHT  current grid, same bit mapping as `load_data`.
- population  output  $clog2(WIDTH*HEIGHT+1)  count of live cells in `grid_out`.
- gen_count  output  16  generations since the last load or reset.
- stable  output  1  last committed generation equalled its predecessor.

## Operation
- FSM states:
  - IDLE: `load_en` has priority. A load sets grid=load_data, gen_count=0, stable=0, population=popcount(load_data). Otherwise `step` goes to COMPUTE with row=0.
  - COMPUTE: each cycle computes next-row[row] from the current grid into a WIDTH*HEIGHT next buffer, then row++. After row HEIGHT-1 the FSM goes to COMMIT.
  - COMMIT: grid=next, gen_count+=1 (wraps 0xFFFF->0), population=popcount(next), stable=(next==grid), done=1, then IDLE.
- The current grid is never modified during COMPUTE, so every row reads generation g only.
- Next-state rule: n = live neighbours among the 8 surrounding cells (0..8).
  - Cell alive: next = SURVIVE_MASK[n].
  - Cell dead: next = BIRTH_MASK[n].
- Neighbour indexing:
  - WRAP=1: x-1, x+1, y-1, y+1 taken modulo WIDTH or HEIGHT.
  - WRAP=0: out-of-range neighbours count as 0.
- `step` or `load_en` while busy are ignored and not queued.
- `load_en` and `step` high together in IDLE: load wins and the step is dropped.
- `population` and `stable` are registered. They change only on a load, a commit or reset.

## Timing
- Reset, asynchronous: state=IDLE, row=0, grid_out=0, next buffer=0, population=0, gen_count=0, stable=0, busy=0, done=0.
- Reset asserted mid-COMPUTE or mid-COMMIT aborts the generation with no partial grid update. Operation restarts on the first rising edge after deassertion.
- `step` sampled at edge E0 in IDLE:
  - busy=1 after E0.
  - Rows 0..HEIGHT-1 are computed at edges E1..E_HEIGHT.
  - COMMIT takes effect at edge E_HEIGHT+1: grid_out, gen_count, population and stable update, done=1 and busy=0 after that edge.
- `done` is high for exactly one cycle. `busy` is high for exactly HEIGHT+1 cycles.
- Back-to-back: a `step` held high in the cycle after done is accepted. Continuous stepping yields one generation per HEIGHT+2 cycles.
- A load takes effect on the edge it is sampled. grid_out and population are valid the next cycle.

## Test plan
- Blinker, 5x5, WRAP=0: load 0x3800, then step. Require busy for 6 cycles, done one cycle, grid_out=0x21080, population=3, gen_count=1, stable=0. A second step returns 0x3800 with gen_count=2.
- Still block, 4x4, WRAP=0: load 0x660, then step. Require grid_out=0x660, population=4, stable=1. Then load 0x001 and step: grid_out=0, population=0, stable=0.
- Edge wrap, 4x4: load 0xB0 and step.
  - WRAP=1: grid_out=0x111, population=3.
  - WRAP=0: grid_out=0x000.
- Ignored requests, 5x5 blinker: assert load_en=1 with data 0x1 during COMPUTE, and pulse step during COMPUTE. Require the commit result 0x21080, exactly one done, and a grid unchanged by the load. Then assert load_en and step together in IDLE: the grid is loaded, gen_count=0, and busy stays 0.
- Reset mid-run: assert reset at row 2 of a 5x5 blinker step. Require grid_out=0, population=0, gen_count=0, busy=0 immediately, and no done pulse after deassertion.
- gen_count wrap: force or run gen_count to 0xFFFF on a still block, then step. Require gen_count=0x0000 and stable=1.
